// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl -- core-local trap sequencer.
//
// Detects ecall / ebreak / mret in the execute stage, and level interrupt
// requests. It stalls the pipeline while it writes mepc, mcause and mstatus
// (or only mstatus for mret) through the CSR file's clint-side write port.
// It then issues a one-cycle PC redirect to mtvec, or to mepc for mret.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   inst_i             instruction in the execute stage
//   inst_addr_i        address of inst_i
//   inst_valid_i       inst_i is a real instruction, not a bubble
//   int_flag_i         level interrupt requests; bit0 timer, bits[7:1] external
//   global_int_en_i    mstatus.MIE tap
//   csr_mtvec_i        mtvec tap
//   csr_mepc_i         mepc tap
//   csr_mstatus_i      mstatus tap
//   csr_mie_i          mie tap (present only with CLINT_MIE_EN)
//   csr_we_o           CSR write enable
//   csr_waddr_o        CSR write address
//   csr_wdata_o        CSR write data
//   hold_flag_o        pipeline stall
//   int_assert_o       one-cycle PC redirect strobe
//   int_addr_o         redirect target, valid with int_assert_o
//
// Optional build macro:
//   CLINT_MIE_EN  adds csr_mie_i. Timer requests are then gated by MTIE
//                 (mie[7]) and external requests by MEIE (mie[11]).

module clint_trap_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     inst_i,
  input  logic [DATA_WIDTH-1:0]     inst_addr_i,
  input  logic                      inst_valid_i,
  input  logic [7:0]                int_flag_i,
  input  logic                      global_int_en_i,
  input  logic [DATA_WIDTH-1:0]     csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0]     csr_mepc_i,
  input  logic [DATA_WIDTH-1:0]     csr_mstatus_i,
`ifdef CLINT_MIE_EN
  input  logic [DATA_WIDTH-1:0]     csr_mie_i,
`endif
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      hold_flag_o,
  output logic                      int_assert_o,
  output logic [DATA_WIDTH-1:0]     int_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] cause, cause_nxt;
  logic [DATA_WIDTH-1:0] ret, ret_nxt;
  logic [DATA_WIDTH-1:0] target, target_nxt;

  logic                  is_ecall, is_ebreak, is_mret;
  logic [7:0]            int_elig;
  logic                  int_req;
  logic [DATA_WIDTH-1:0] int_cause;
  logic [DATA_WIDTH-1:0] mstatus_trap, mstatus_mret;
  logic [11:0]           waddr;

  assign is_ecall  = inst_valid_i && (inst_i == DATA_WIDTH'(32'h0000_0073));
  assign is_ebreak = inst_valid_i && (inst_i == DATA_WIDTH'(32'h0010_0073));
  assign is_mret   = inst_valid_i && (inst_i == DATA_WIDTH'(32'h3020_0073));

`ifdef CLINT_MIE_EN
  assign int_elig = {int_flag_i[7:1] & {7{csr_mie_i[11]}},
                     int_flag_i[0] & csr_mie_i[7]};
`else
  assign int_elig = int_flag_i;
`endif

  // Interrupts are only taken against a real instruction, which gets
  // squashed and re-executed after the handler returns.
  assign int_req   = inst_valid_i && global_int_en_i && (|int_elig);
  assign int_cause = int_elig[0] ? DATA_WIDTH'(32'h8000_0007)
                                 : DATA_WIDTH'(32'h8000_000B);

  // Trap entry: MPIE <= MIE, MIE <= 0. Mret: MIE <= MPIE, MPIE <= 1.
  always_comb begin
    mstatus_trap    = csr_mstatus_i;
    mstatus_trap[7] = csr_mstatus_i[3];
    mstatus_trap[3] = 1'b0;
    mstatus_mret    = csr_mstatus_i;
    mstatus_mret[3] = csr_mstatus_i[7];
    mstatus_mret[7] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cause  <= '0;
      ret    <= '0;
      target <= '0;
    end else begin
      state  <= state_nxt;
      cause  <= cause_nxt;
      ret    <= ret_nxt;
      target <= target_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause;
    ret_nxt      = ret;
    target_nxt   = target;
    csr_we_o     = 1'b0;
    waddr        = '0;
    csr_wdata_o  = '0;
    hold_flag_o  = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    case (state)
      S_IDLE: begin
        // Synchronous events win over interrupts; a pending level
        // interrupt is simply seen again on a later IDLE cycle.
        if (is_ecall || is_ebreak) begin
          hold_flag_o = 1'b1;
          cause_nxt   = is_ecall ? DATA_WIDTH'(32'd11) : DATA_WIDTH'(32'd3);
          ret_nxt     = inst_addr_i;
          state_nxt   = S_W_MEPC;
        end else if (is_mret) begin
          hold_flag_o = 1'b1;
          state_nxt   = S_W_MRET;
        end else if (int_req) begin
          hold_flag_o = 1'b1;
          cause_nxt   = int_cause;
          ret_nxt     = inst_addr_i;
          state_nxt   = S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        waddr       = ADDR_MEPC;
        csr_wdata_o = ret;
        state_nxt   = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        waddr       = ADDR_MCAUSE;
        csr_wdata_o = cause;
        state_nxt   = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        waddr       = ADDR_MSTATUS;
        csr_wdata_o = mstatus_trap;
        target_nxt  = csr_mtvec_i;
        state_nxt   = S_ASSERT;
      end
      S_W_MRET: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        waddr       = ADDR_MSTATUS;
        csr_wdata_o = mstatus_mret;
        target_nxt  = csr_mepc_i;
        state_nxt   = S_ASSERT;
      end
      S_ASSERT: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = target;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign csr_waddr_o = CSR_ADDR_WIDTH'(waddr);

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed bench for clint_trap_ctrl: a table of single-event vectors,
// each stepped through its full write/redirect sequence, plus hand-written
// reset sequences.

module tb_clint_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  localparam int K_NONE = 0;
  localparam int K_TRAP = 1;
  localparam int K_MRET = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, inst_addr;
  logic        inst_valid;
  logic [7:0]  int_flag;
  logic        global_int_en;
  logic [31:0] csr_mtvec, csr_mepc, csr_mstatus, csr_mie;
  logic        csr_we;
  logic [31:0] csr_waddr, csr_wdata;
  logic        hold_flag, int_assert;
  logic [31:0] int_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clint_trap_ctrl #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_i         (inst),
    .inst_addr_i    (inst_addr),
    .inst_valid_i   (inst_valid),
    .int_flag_i     (int_flag),
    .global_int_en_i(global_int_en),
    .csr_mtvec_i    (csr_mtvec),
    .csr_mepc_i     (csr_mepc),
    .csr_mstatus_i  (csr_mstatus),
`ifdef CLINT_MIE_EN
    .csr_mie_i      (csr_mie),
`endif
    .csr_we_o       (csr_we),
    .csr_waddr_o    (csr_waddr),
    .csr_wdata_o    (csr_wdata),
    .hold_flag_o    (hold_flag),
    .int_assert_o   (int_assert),
    .int_addr_o     (int_addr)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        valid;
    logic [7:0]  irq;
    logic        gie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic [31:0] mie;
    int          kind;
    logic [31:0] e_mepc;
    logic [31:0] e_cause;
    logic [31:0] e_mstatus;
    logic [31:0] e_target;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [31:0] i, a,
                              input logic v, input logic [7:0] irq,
                              input logic gie, input logic [31:0] tv, ep, ms, mie,
                              input int kind, input logic [31:0] em, ec, es, et);
    vec_t r;
    r.name = name; r.inst = i; r.addr = a; r.valid = v; r.irq = irq;
    r.gie = gie; r.mtvec = tv; r.mepc = ep; r.mstatus = ms; r.mie = mie;
    r.kind = kind; r.e_mepc = em; r.e_cause = ec; r.e_mstatus = es;
    r.e_target = et;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_write(input string nm, input logic [31:0] wa, input logic [31:0] wd);
    chk({nm, " we"},    32'(csr_we), 32'd1);
    chk({nm, " waddr"}, csr_waddr, wa);
    chk({nm, " wdata"}, csr_wdata, wd);
    chk({nm, " hold"},  32'(hold_flag), 32'd1);
    chk({nm, " assert"}, 32'(int_assert), 32'd0);
  endtask

  task automatic chk_quiet(input string nm, input logic exp_hold);
    chk({nm, " we"},     32'(csr_we), 32'd0);
    chk({nm, " waddr"},  csr_waddr, 32'd0);
    chk({nm, " wdata"},  csr_wdata, 32'd0);
    chk({nm, " hold"},   32'(hold_flag), 32'(exp_hold));
    chk({nm, " assert"}, 32'(int_assert), 32'd0);
    chk({nm, " iaddr"},  int_addr, 32'd0);
  endtask

  task automatic drive_idle();
    inst = NOP; inst_addr = '0; inst_valid = 1'b0; int_flag = '0;
    global_int_en = 1'b0; csr_mtvec = '0; csr_mepc = '0;
    csr_mstatus = '0; csr_mie = '0;
  endtask

  // Inputs stay applied through the whole sequence, so any re-detection
  // outside IDLE would disturb the expected writes.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    inst = v.inst; inst_addr = v.addr; inst_valid = v.valid;
    int_flag = v.irq; global_int_en = v.gie; csr_mtvec = v.mtvec;
    csr_mepc = v.mepc; csr_mstatus = v.mstatus; csr_mie = v.mie;
    #1;
    chk_quiet({v.name, " detect"}, v.kind != K_NONE);
    if (v.kind == K_TRAP) begin
      @(negedge clk); #1;
      chk_write({v.name, " mepc"}, 32'h341, v.e_mepc);
      @(negedge clk); #1;
      chk_write({v.name, " mcause"}, 32'h342, v.e_cause);
      @(negedge clk); #1;
      chk_write({v.name, " mstatus"}, 32'h300, v.e_mstatus);
    end else if (v.kind == K_MRET) begin
      @(negedge clk); #1;
      chk_write({v.name, " mret"}, 32'h300, v.e_mstatus);
    end
    if (v.kind != K_NONE) begin
      @(negedge clk); #1;
      chk({v.name, " assert"}, 32'(int_assert), 32'd1);
      chk({v.name, " target"}, int_addr, v.e_target);
      chk({v.name, " asrt hold"}, 32'(hold_flag), 32'd1);
      chk({v.name, " asrt we"}, 32'(csr_we), 32'd0);
      chk({v.name, " asrt waddr"}, csr_waddr, 32'd0);
    end
    inst_valid = 1'b0; int_flag = '0;
    @(negedge clk); #1;
    chk_quiet({v.name, " after"}, 1'b0);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset", 1'b0);
    rst_n = 1'b1;

    vecs.push_back(mk("ecall",    ECALL,  32'h100, 1, 8'h00, 0, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_TRAP, 32'h100, 32'd11, 32'h80, 32'h400));
    vecs.push_back(mk("ebreak",   EBREAK, 32'h104, 1, 8'h00, 0, 32'h800, 32'h0, 32'h0, 32'h880,
                      K_TRAP, 32'h104, 32'd3, 32'h0, 32'h800));
    vecs.push_back(mk("mret",     MRET,   32'h108, 1, 8'h00, 0, 32'h0, 32'h104, 32'h80, 32'h880,
                      K_MRET, 32'h0, 32'h0, 32'h88, 32'h104));
    vecs.push_back(mk("mret_mp0", MRET,   32'h10C, 1, 8'h00, 0, 32'h0, 32'h300, 32'h1800, 32'h880,
                      K_MRET, 32'h0, 32'h0, 32'h1880, 32'h300));
    vecs.push_back(mk("timer",    NOP,    32'h200, 1, 8'h01, 1, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_TRAP, 32'h200, 32'h8000_0007, 32'h80, 32'h400));
    vecs.push_back(mk("ext",      NOP,    32'h204, 1, 8'h04, 1, 32'h440, 32'h0, 32'h88, 32'h880,
                      K_TRAP, 32'h204, 32'h8000_000B, 32'h80, 32'h440));
    vecs.push_back(mk("gie_off",  NOP,    32'h208, 1, 8'h01, 0, 32'h400, 32'h0, 32'h0, 32'h880,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk("tmr_prio", NOP,    32'h20C, 1, 8'h05, 1, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_TRAP, 32'h20C, 32'h8000_0007, 32'h80, 32'h400));
    vecs.push_back(mk("ecall_irq", ECALL, 32'h300, 1, 8'h02, 1, 32'h400, 32'h0, 32'h88, 32'h880,
                      K_TRAP, 32'h300, 32'd11, 32'h80, 32'h400));
    vecs.push_back(mk("pend_mie0", NOP,   32'h400, 1, 8'h02, 0, 32'h400, 32'h0, 32'h80, 32'h880,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk("pend_mie1", NOP,   32'h400, 1, 8'h02, 1, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_TRAP, 32'h400, 32'h8000_000B, 32'h80, 32'h400));
    vecs.push_back(mk("bubble_irq", NOP,  32'h500, 0, 8'h80, 1, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk("bubble_ecall", ECALL, 32'h504, 0, 8'h00, 1, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk("mret_irq", MRET,   32'h508, 1, 8'h01, 1, 32'h0, 32'h600, 32'h80, 32'h880,
                      K_MRET, 32'h0, 32'h0, 32'h88, 32'h600));
    vecs.push_back(mk("ms_ones",  EBREAK, 32'h50C, 1, 8'h00, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 32'h880,
                      K_TRAP, 32'h50C, 32'd3, 32'hFFFF_FFF7, 32'hFFFF_FFFC));
    vecs.push_back(mk("mret_ones", MRET,  32'h510, 1, 8'h00, 0, 32'h0, 32'h1234_5678, 32'hFFFF_FF77, 32'h880,
                      K_MRET, 32'h0, 32'h0, 32'hFFFF_FFF7, 32'h1234_5678));
    vecs.push_back(mk("not_sys",  32'h0020_0073, 32'h514, 1, 8'h00, 1, 32'h400, 32'h0, 32'h8, 32'h880,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
`ifdef CLINT_MIE_EN
    vecs.push_back(mk("mie_tmr_off", NOP, 32'h600, 1, 8'h01, 1, 32'h400, 32'h0, 32'h8, 32'h800,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
    vecs.push_back(mk("mie_ext_only", NOP, 32'h604, 1, 8'h03, 1, 32'h400, 32'h0, 32'h8, 32'h800,
                      K_TRAP, 32'h604, 32'h8000_000B, 32'h80, 32'h400));
    vecs.push_back(mk("mie_ext_off", NOP, 32'h608, 1, 8'h02, 1, 32'h400, 32'h0, 32'h8, 32'h080,
                      K_NONE, 32'h0, 32'h0, 32'h0, 32'h0));
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while mcause is being written: the sequence must not resume.
    @(negedge clk);
    inst = ECALL; inst_addr = 32'h700; inst_valid = 1'b1; int_flag = '0;
    global_int_en = 1'b0; csr_mtvec = 32'h800; csr_mstatus = 32'h8;
    #1;
    chk("rst_seq detect hold", 32'(hold_flag), 32'd1);
    @(negedge clk); #1;
    chk_write("rst_seq mepc", 32'h341, 32'h700);
    @(negedge clk); #1;
    chk_write("rst_seq mcause", 32'h342, 32'd11);
    rst_n = 1'b0; inst_valid = 1'b0;
    @(negedge clk); #1;
    chk_quiet("rst_seq in_reset", 1'b0);
    rst_n = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk_quiet("rst_seq post", 1'b0);
    end

    // A fresh sequence after the abort starts cleanly from mepc.
    run_vec(mk("post_rst", ECALL, 32'h710, 1, 8'h00, 0, 32'h900, 32'h0, 32'h8, 32'h880,
               K_TRAP, 32'h710, 32'd11, 32'h80, 32'h900));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clint_trap_ctrl.md
Name: clint_trap_ctrl

Overview:
- Core-local trap sequencer. Drives the CSR file's clint-side write port and consumes its mtvec/mepc/mstatus taps and global-interrupt-enable.
- Detects ecall, ebreak and mret in the execute stage, plus external/timer interrupt lines.
- Stalls the pipeline while it sequences mepc/mcause/mstatus writes, then redirects the PC to the trap vector (or to mepc on mret).

Parameters:
- DATA_WIDTH, 32, CSR data width and instruction/address width.
- CSR_ADDR_WIDTH, 32, width of the CSR write address; only bits [11:0] are significant, upper bits are driven 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- inst_i  in  DATA_WIDTH  instruction in execute stage
- inst_addr_i  in  DATA_WIDTH  address of inst_i
- inst_valid_i  in  1  inst_i is a real instruction (not a bubble)
- int_flag_i  in  8  interrupt requests, level; bit0 timer, bits[7:1] external
- global_int_en_i  in  1  mstatus.MIE tap from CSR file
- csr_mtvec_i  in  DATA_WIDTH  mtvec tap
- csr_mepc_i  in  DATA_WIDTH  mepc tap
- csr_mstatus_i  in  DATA_WIDTH  mstatus tap
- csr_we_o  out  1  CSR write enable (to the clint write port)
- csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
- csr_wdata_o  out  DATA_WIDTH  CSR write data
- hold_flag_o  out  1  pipeline stall; the core suppresses the execute instruction's commit while this is high
- int_assert_o  out  1  one-cycle PC redirect strobe
- int_addr_o  out  DATA_WIDTH  redirect target, valid with int_assert_o

Behaviour:
- Decode, valid only with inst_valid_i: ECALL=0x00000073, EBREAK=0x00100073, MRET=0x30200073.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, ASSERT.
- Reset: state IDLE. All outputs 0. Latched cause/return-addr/target registers 0.
- Reset mid-sequence aborts immediately; there are no partial-write side effects after reset.

IDLE, priority order:
- ECALL or EBREAK: cause=11 (ecall) or 3 (ebreak); ret=inst_addr_i; go to W_MEPC.
- MRET: go to W_MRET.
- Else, if inst_valid_i & global_int_en_i & |int_flag_i: cause=0x80000007 if int_flag_i[0], else 0x8000000B; ret=inst_addr_i (the instruction is squashed and re-executed); go to W_MEPC.
- Async requests are not taken while inst_valid_i=0.
- hold_flag_o is high combinationally in the detection cycle, and in every non-IDLE state.

Trap entry sequence:
- W_MEPC: we=1, waddr=0x341, wdata=ret.
- W_MCAUSE: we=1, waddr=0x342, wdata=cause.
- W_MSTATUS: we=1, waddr=0x300, wdata=csr_mstatus_i with bit7(MPIE) set to csr_mstatus_i[3] and bit3(MIE) cleared. Latch target=csr_mtvec_i.
- ASSERT: int_assert_o=1, int_addr_o=target, hold_flag_o=1; go to IDLE.

Mret sequence:
- W_MRET: we=1, waddr=0x300, wdata=csr_mstatus_i with bit3 set to csr_mstatus_i[7] and bit7 set to 1. Latch target=csr_mepc_i.
- ASSERT: as above.

Timing and rules:
- Latency from detection to int_assert_o: 4 cycles for a trap, 2 cycles for mret.
- csr_we_o is 0 in IDLE and ASSERT. csr_waddr_o and csr_wdata_o are 0 whenever csr_we_o=0.
- int_addr_o is 0 when int_assert_o=0.
- Since hold_flag_o freezes execute, no execute-side CSR write can collide with a clint write during the sequence.
- New requests arriving in non-IDLE states are ignored; level interrupts are re-evaluated in IDLE.
- The interrupt taken immediately after an mret redirect is evaluated against the restored MIE.
- Simultaneous ECALL/EBREAK/MRET plus interrupt: the synchronous event wins and the interrupt stays pending.

Optional Feature:
- Macro CLINT_MIE_EN adds input csr_mie_i (DATA_WIDTH, mie tap).
- With CLINT_MIE_EN: int_flag_i[0] is eligible only if csr_mie_i[7] (MTIE); int_flag_i[7:1] are eligible only if csr_mie_i[11] (MEIE). Cause selection uses the eligible bits only.
- Without CLINT_MIE_EN: no csr_mie_i port; all lines are gated by global_int_en_i alone.

Test Plan:
- ECALL at inst_addr_i=0x100, mstatus=0x8, mtvec=0x400 -> mepc=0x100 written, then mcause=11, then mstatus=0x80, then int_assert_o with int_addr_o=0x400. hold_flag_o is high for 5 cycles.
- MRET with mstatus=0x80, mepc=0x104 -> mstatus write 0x88, then int_assert_o with int_addr_o=0x104, 2 cycles after detection.
- int_flag_i=0x01, global_int_en_i=1, valid inst at 0x200 -> mepc=0x200, mcause=0x80000007. With int_flag_i=0x04 instead -> mcause=0x8000000B. With global_int_en_i=0 -> no action.
- ECALL and int_flag_i=0x02 in the same cycle -> mcause=11. After ASSERT, MIE is 0, so the interrupt is not taken until software re-enables it.
- rst_n low during W_MCAUSE -> next cycle IDLE, all outputs 0, no further CSR writes.
- CLINT_MIE_EN with mie=0x800, int_flag_i=0x01 -> ignored; int_flag_i=0x03 -> mcause=0x8000000B.
